// File: rtl/usb_ep_out_drain_arbiter.sv
// Drains N OUT-endpoint FIFOs onto one byte stream: round-robin packet pick, byte streaming,
// and commit/rewind closure from consumer verdict, stall watchdog or endpoint disable.
//
// state          | meaning
// ---------------+----------------------------------------------------------
// S_IDLE         | scanning endpoints from rr pointer for a ready packet
// S_STREAM       | forwarding bytes of the selected endpoint's packet
// S_WAIT_VERDICT | last byte delivered, waiting for accept/reject
// S_COMMIT       | one-cycle Done pulse with latched verdict
// S_ABORT        | one-cycle Done pulse with rewind, plus abort to consumer
module usb_ep_out_drain_arbiter #(
  parameter  int EP_COUNT    = 4,
  parameter  int STALL_LIMIT = 255,
  localparam int EP_IDX_WID  = $clog2(EP_COUNT)
) (
  input  logic                       clk12_i,
  input  logic                       rst_ni,
  input  logic [EP_COUNT-1:0]        epEnable_i,
  input  logic [EP_COUNT-1:0]        EP_dataAvailable_i,
  input  logic [EP_COUNT-1:0]        EP_isLastPacketByte_i,
  input  logic [EP_COUNT-1:0][7:0]   EP_data_i,
  output logic [EP_COUNT-1:0]        EP_popData_o,
  output logic [EP_COUNT-1:0]        EP_popTransDone_o,
  output logic [EP_COUNT-1:0]        EP_popTransSuccess_o,
  output logic                       out_valid_o,
  input  logic                       out_ready_i,
  output logic [7:0]                 out_data_o,
  output logic                       out_last_o,
  output logic [EP_IDX_WID-1:0]      out_epIdx_o,
  output logic                       out_abort_o,
  input  logic                       verdictAccept_i,
  input  logic                       verdictReject_i
);

  localparam int CNT_WID = $clog2(STALL_LIMIT + 1);
  localparam int IW1     = EP_IDX_WID + 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_STREAM,
    S_WAIT_VERDICT,
    S_COMMIT,
    S_ABORT
  } state_t;

  state_t                r_state, w_state_nxt;
  logic [EP_IDX_WID-1:0] r_rr_ptr, w_rr_ptr_nxt;
  logic [EP_IDX_WID-1:0] r_sel, w_sel_nxt;
  logic [CNT_WID-1:0]    r_stall_cnt, w_stall_cnt_nxt;
  logic                  r_verdict, w_verdict_nxt;

  logic [EP_COUNT-1:0]   w_eligible;
  logic                  w_found;
  logic [EP_IDX_WID-1:0] w_pick;
  logic [IW1-1:0]        w_idx;
  logic [EP_IDX_WID-1:0] w_sel_plus1;
  logic                  w_sel_avail;
  logic                  w_sel_en;
  logic                  w_hs;

  assign w_eligible  = epEnable_i & EP_dataAvailable_i;
  assign w_sel_plus1 = (r_sel == EP_IDX_WID'(EP_COUNT - 1)) ? '0 : r_sel + 1'b1;
  assign w_sel_avail = EP_dataAvailable_i[r_sel];
  assign w_sel_en    = epEnable_i[r_sel];
  assign w_hs        = w_sel_en && w_sel_avail && out_ready_i;
  assign out_epIdx_o = r_sel;

  // Rotating priority: first eligible endpoint at or after the rr pointer.
  always_comb begin
    w_found = 1'b0;
    w_pick  = '0;
    w_idx   = '0;
    for (int k = 0; k < EP_COUNT; k++) begin
      w_idx = {1'b0, r_rr_ptr} + IW1'(k);
      if (w_idx >= IW1'(EP_COUNT)) w_idx = w_idx - IW1'(EP_COUNT);
      if (!w_found && w_eligible[w_idx[EP_IDX_WID-1:0]]) begin
        w_found = 1'b1;
        w_pick  = w_idx[EP_IDX_WID-1:0];
      end
    end
  end

  always_ff @(posedge clk12_i) begin
    if (!rst_ni) begin
      r_state     <= S_IDLE;
      r_rr_ptr    <= '0;
      r_sel       <= '0;
      r_stall_cnt <= '0;
      r_verdict   <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_rr_ptr    <= w_rr_ptr_nxt;
      r_sel       <= w_sel_nxt;
      r_stall_cnt <= w_stall_cnt_nxt;
      r_verdict   <= w_verdict_nxt;
    end
  end

  always_comb begin
    w_state_nxt          = r_state;
    w_rr_ptr_nxt         = r_rr_ptr;
    w_sel_nxt            = r_sel;
    w_stall_cnt_nxt      = r_stall_cnt;
    w_verdict_nxt        = r_verdict;
    EP_popData_o         = '0;
    EP_popTransDone_o    = '0;
    EP_popTransSuccess_o = '0;
    out_valid_o          = 1'b0;
    out_data_o           = '0;
    out_last_o           = 1'b0;
    out_abort_o          = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (w_found) begin
          w_sel_nxt       = w_pick;
          w_stall_cnt_nxt = '0;
          w_state_nxt     = S_STREAM;
        end
      end

      S_STREAM: begin
        // A disabled endpoint is dropped before any handshake is offered.
        if (!w_sel_en) begin
          w_state_nxt = S_ABORT;
        end else begin
          out_valid_o         = w_sel_avail;
          out_data_o          = EP_data_i[r_sel];
          out_last_o          = EP_isLastPacketByte_i[r_sel];
          EP_popData_o[r_sel] = out_ready_i && w_sel_avail;
          if (w_hs) begin
            w_stall_cnt_nxt = '0;
            if (EP_isLastPacketByte_i[r_sel]) w_state_nxt = S_WAIT_VERDICT;
          end else begin
            if (r_stall_cnt != CNT_WID'(STALL_LIMIT)) w_stall_cnt_nxt = r_stall_cnt + 1'b1;
            if (r_stall_cnt == CNT_WID'(STALL_LIMIT - 1)) w_state_nxt = S_ABORT;
          end
        end
      end

      S_WAIT_VERDICT: begin
        if (verdictAccept_i) begin
          w_verdict_nxt = 1'b1;
          w_state_nxt   = S_COMMIT;
        end else if (verdictReject_i) begin
          w_verdict_nxt = 1'b0;
          w_state_nxt   = S_COMMIT;
        end
      end

      S_COMMIT: begin
        EP_popTransDone_o[r_sel]    = 1'b1;
        EP_popTransSuccess_o[r_sel] = r_verdict;
        w_rr_ptr_nxt                = w_sel_plus1;
        w_state_nxt                 = S_IDLE;
      end

      S_ABORT: begin
        out_abort_o              = 1'b1;
        EP_popTransDone_o[r_sel] = 1'b1;
        w_rr_ptr_nxt             = w_sel_plus1;
        w_state_nxt              = S_IDLE;
      end

      default: w_state_nxt = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_usb_ep_out_drain_arbiter.sv
// Bench for usb_ep_out_drain_arbiter: cycle vector table, directed corner sequences,
// and randomized traffic against a per-cycle behavioural reference with endpoint FIFO models.
module tb_usb_ep_out_drain_arbiter;
  localparam int N   = 4;
  localparam int LIM = 8;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [N-1:0]      en, av, lst;
  logic [N-1:0][7:0] dat;
  logic              rdy, acc, rej;
  logic [N-1:0]      pop, done, succ;
  logic              valid, olast, abort;
  logic [7:0]        odata;
  logic [1:0]        idx;

  usb_ep_out_drain_arbiter #(.EP_COUNT(N), .STALL_LIMIT(LIM)) dut (
    .clk12_i(clk), .rst_ni(rst_n), .epEnable_i(en), .EP_dataAvailable_i(av),
    .EP_isLastPacketByte_i(lst), .EP_data_i(dat), .EP_popData_o(pop),
    .EP_popTransDone_o(done), .EP_popTransSuccess_o(succ), .out_valid_o(valid),
    .out_ready_i(rdy), .out_data_o(odata), .out_last_o(olast), .out_epIdx_o(idx),
    .out_abort_o(abort), .verdictAccept_i(acc), .verdictReject_i(rej)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic [3:0] en, av, ls; logic [31:0] d; logic r, a, j;
    logic ev; logic [7:0] ed; logic el; logic [3:0] ep, edn, es; logic [1:0] ei; logic ea;
  } vec_t;
  vec_t tv[17];

  function automatic vec_t V(logic [3:0] en_, av_, ls_, logic [31:0] d_, logic r_, a_, j_,
                             logic ev, logic [7:0] ed, logic el, logic [3:0] ep, edn, es,
                             logic [1:0] ei, logic ea);
    vec_t t;
    t = '{en_, av_, ls_, d_, r_, a_, j_, ev, ed, el, ep, edn, es, ei, ea};
    return t;
  endfunction

  // Endpoint models: one head packet per endpoint with a read offset that a rewind resets.
  logic [7:0] pk[N][8];
  int         plen[N];
  bit         has[N];
  int         ro[N];

  // Reference state, phases named after the specified states.
  localparam int PH_IDLE = 0, PH_STREAM = 1, PH_WAIT = 2, PH_COMMIT = 3, PH_ABORT = 4;
  int m_ph, m_rr, m_sel, m_stall;
  bit m_vd;

  logic [N-1:0] g_en, g_gap;
  bit           g_rdy, g_acc, g_rej, g_last_ab;
  int           done_ep_q[$];
  bit           done_s_q[$];
  logic [7:0]   rx_q[$];

  task automatic chk(input string name, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic load(input int e, input int len, input logic [7:0] base);
    has[e] = 1'b1; ro[e] = 0; plen[e] = len;
    for (int b = 0; b < len; b++) pk[e][b] = base + 8'(b);
  endtask

  task automatic model_reset();
    m_ph = PH_IDLE; m_rr = 0; m_sel = 0; m_stall = 0; m_vd = 1'b0;
  endtask

  task automatic tick(input bit rst_val);
    logic [N-1:0] a, e_pop, e_done, e_succ;
    logic         e_val, e_last, e_ab, bad;
    logic [7:0]   e_dat;
    logic [1:0]   e_idx;
    int           nph, nrr, nsel, nst;
    bit           nvd, found;
    @(negedge clk);
    for (int e = 0; e < N; e++) begin
      a[e]   = has[e] && (ro[e] < plen[e]) && !g_gap[e];
      dat[e] = a[e] ? pk[e][ro[e]] : 8'h00;
      lst[e] = a[e] && (ro[e] == plen[e] - 1);
    end
    av = a; en = g_en; rst_n = rst_val; rdy = g_rdy; acc = g_acc; rej = g_rej;
    #1;
    e_val = 0; e_last = 0; e_ab = 0; e_dat = '0; e_pop = '0; e_done = '0; e_succ = '0;
    e_idx = m_sel[1:0];
    nph = m_ph; nrr = m_rr; nsel = m_sel; nst = m_stall; nvd = m_vd; found = 0;
    case (m_ph)
      PH_IDLE: for (int k = 0; k < N; k++) begin
        int i;
        i = (m_rr + k) % N;
        if (!found && g_en[i] && a[i]) begin
          found = 1; nsel = i; nst = 0; nph = PH_STREAM;
        end
      end
      PH_STREAM: begin
        if (!g_en[m_sel]) nph = PH_ABORT;
        else begin
          e_val = a[m_sel];
          e_pop[m_sel] = g_rdy && a[m_sel];
          if (a[m_sel]) begin
            e_dat  = pk[m_sel][ro[m_sel]];
            e_last = (ro[m_sel] == plen[m_sel] - 1);
          end
          if (a[m_sel] && g_rdy) begin
            nst = 0;
            if (e_last) nph = PH_WAIT;
          end else begin
            nst = m_stall + 1;
            if (nst >= LIM) nph = PH_ABORT;
          end
        end
      end
      PH_WAIT: begin
        if (g_acc) begin nvd = 1; nph = PH_COMMIT; end
        else if (g_rej) begin nvd = 0; nph = PH_COMMIT; end
      end
      PH_COMMIT: begin
        e_done[m_sel] = 1; e_succ[m_sel] = m_vd; nrr = (m_sel + 1) % N; nph = PH_IDLE;
      end
      default: begin
        e_ab = 1; e_done[m_sel] = 1; nrr = (m_sel + 1) % N; nph = PH_IDLE;
      end
    endcase
    n_cmp++;
    bad = (valid !== e_val) || (pop !== e_pop) || (done !== e_done) || (succ !== e_succ) ||
          (abort !== e_ab) || (idx !== e_idx) || (e_val && ((odata !== e_dat) || (olast !== e_last)));
    if (bad) begin
      n_bad++;
      $display("FAIL cycle_ref t=%0t: got v=%b d=%h l=%b pop=%b done=%b succ=%b idx=%0d ab=%b, expected v=%b d=%h l=%b pop=%b done=%b succ=%b idx=%0d ab=%b",
               $time, valid, odata, olast, pop, done, succ, idx, abort,
               e_val, e_dat, e_last, e_pop, e_done, e_succ, e_idx, e_ab);
    end
    g_last_ab = abort;
    if (valid && rdy) rx_q.push_back(odata);
    for (int e = 0; e < N; e++) begin
      if (done[e]) begin done_ep_q.push_back(e); done_s_q.push_back(succ[e]); end
      if (pop[e]) ro[e]++;
      if (done[e]) begin ro[e] = 0; if (succ[e]) has[e] = 0; end
    end
    if (rst_val) begin
      m_ph = nph; m_rr = nrr; m_sel = nsel; m_stall = nst; m_vd = nvd;
    end else model_reset();
  endtask

  task automatic wait_done(input int exp_ep, input bit exp_s, input string name);
    int guard = 0;
    while (done_ep_q.size() == 0 && guard < 300) begin tick(1); guard++; end
    if (done_ep_q.size() == 0) begin
      chk({name, "_timeout"}, 0, 1);
    end else begin
      chk({name, "_ep"}, done_ep_q.pop_front(), exp_ep);
      chk({name, "_succ"}, int'(done_s_q.pop_front()), int'(exp_s));
    end
  endtask

  task automatic wait_rx(input int target);
    int guard = 0;
    while (rx_q.size() < target && guard < 50) begin tick(1); guard++; end
    if (rx_q.size() < target) chk("rx_timeout", rx_q.size(), target);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int rx0, ab_at;
    rst_n = 0; en = '0; av = '0; lst = '0; dat = '0; rdy = 0; acc = 0; rej = 0;
    for (int e = 0; e < N; e++) begin has[e] = 0; ro[e] = 0; plen[e] = 0; end
    g_en = '1; g_gap = '0; g_rdy = 1; g_acc = 1; g_rej = 0;
    model_reset();

    //        en    av    ls    data          r  a  j | v  d      l  pop   done  succ  idx ab
    tv[0]  = V(4'hF, 4'h2, 4'h0, 32'h0000A100, 1, 0, 0, 0, 8'h00, 0, 4'h0, 4'h0, 4'h0, 0, 0);
    tv[1]  = V(4'hF, 4'h2, 4'h0, 32'h0000A100, 1, 0, 0, 1, 8'hA1, 0, 4'h2, 4'h0, 4'h0, 1, 0);
    tv[2]  = V(4'hF, 4'h2, 4'h0, 32'h0000A200, 1, 0, 0, 1, 8'hA2, 0, 4'h2, 4'h0, 4'h0, 1, 0);
    tv[3]  = V(4'hF, 4'h2, 4'h2, 32'h0000A300, 1, 0, 0, 1, 8'hA3, 1, 4'h2, 4'h0, 4'h0, 1, 0);
    tv[4]  = V(4'hF, 4'h0, 4'h0, 32'h00000000, 1, 1, 0, 0, 8'h00, 0, 4'h0, 4'h0, 4'h0, 1, 0);
    tv[5]  = V(4'hF, 4'h0, 4'h0, 32'h00000000, 1, 0, 0, 0, 8'h00, 0, 4'h0, 4'h2, 4'h2, 1, 0);
    tv[6]  = V(4'hF, 4'hA, 4'h8, 32'hB100C100, 1, 0, 0, 0, 8'h00, 0, 4'h0, 4'h0, 4'h0, 1, 0);
    tv[7]  = V(4'hF, 4'hA, 4'h8, 32'hB100C100, 1, 0, 0, 1, 8'hB1, 1, 4'h8, 4'h0, 4'h0, 3, 0);
    tv[8]  = V(4'hF, 4'h2, 4'h0, 32'h0000C100, 1, 0, 1, 0, 8'h00, 0, 4'h0, 4'h0, 4'h0, 3, 0);
    tv[9]  = V(4'hF, 4'h2, 4'h0, 32'h0000C100, 1, 0, 0, 0, 8'h00, 0, 4'h0, 4'h8, 4'h0, 3, 0);
    tv[10] = V(4'hF, 4'h2, 4'h0, 32'h0000C100, 1, 0, 0, 0, 8'h00, 0, 4'h0, 4'h0, 4'h0, 3, 0);
    tv[11] = V(4'hF, 4'h2, 4'h0, 32'h0000C100, 0, 0, 0, 1, 8'hC1, 0, 4'h0, 4'h0, 4'h0, 1, 0);
    tv[12] = V(4'hD, 4'h2, 4'h0, 32'h0000C100, 1, 0, 0, 0, 8'h00, 0, 4'h0, 4'h0, 4'h0, 1, 0);
    tv[13] = V(4'hD, 4'h2, 4'h0, 32'h0000C100, 1, 0, 0, 0, 8'h00, 0, 4'h0, 4'h2, 4'h0, 1, 1);
    tv[14] = V(4'hD, 4'h2, 4'h0, 32'h0000C100, 1, 0, 0, 0, 8'h00, 0, 4'h0, 4'h0, 4'h0, 1, 0);
    tv[15] = V(4'hD, 4'h3, 4'h0, 32'h0000C1D0, 1, 0, 0, 0, 8'h00, 0, 4'h0, 4'h0, 4'h0, 1, 0);
    tv[16] = V(4'hD, 4'h3, 4'h0, 32'h0000C1D0, 1, 0, 0, 1, 8'hD0, 0, 4'h1, 4'h0, 4'h0, 0, 0);

    @(negedge clk); rst_n = 0;
    @(negedge clk); rst_n = 1; #1;
    chk("reset_valid", int'(valid), 0);
    chk("reset_outs", int'({pop, done, succ, abort, olast}), 0);
    chk("reset_idx", int'(idx), 0);
    @(posedge clk);

    for (int i = 0; i < 17; i++) begin
      @(negedge clk);
      en = tv[i].en; av = tv[i].av; lst = tv[i].ls; dat = tv[i].d;
      rdy = tv[i].r; acc = tv[i].a; rej = tv[i].j;
      #1;
      n_cmp++;
      if ((valid !== tv[i].ev) || (pop !== tv[i].ep) || (done !== tv[i].edn) ||
          (succ !== tv[i].es) || (idx !== tv[i].ei) || (abort !== tv[i].ea) ||
          (tv[i].ev && ((odata !== tv[i].ed) || (olast !== tv[i].el)))) begin
        n_bad++;
        $display("FAIL vec%0d: got v=%b d=%h l=%b pop=%b done=%b succ=%b idx=%0d ab=%b, expected v=%b d=%h l=%b pop=%b done=%b succ=%b idx=%0d ab=%b",
                 i, valid, odata, olast, pop, done, succ, idx, abort,
                 tv[i].ev, tv[i].ed, tv[i].el, tv[i].ep, tv[i].edn, tv[i].es, tv[i].ei, tv[i].ea);
      end
    end

    // Fresh reset without comparison, then the reference takes over.
    @(negedge clk); rst_n = 0; en = '0; av = '0; rdy = 0; acc = 0; rej = 0;
    model_reset();

    // Round-robin order: rr=0 serves EP0 then EP2; after rr=1, EP2 goes first.
    load(0, 3, 8'h10); load(2, 2, 8'h20);
    wait_done(0, 1, "rr0_first");
    wait_done(2, 1, "rr0_second");
    load(0, 1, 8'h30);
    wait_done(0, 1, "rr_setup");
    load(0, 2, 8'h40); load(2, 2, 8'h50);
    wait_done(2, 1, "rr1_first");
    wait_done(0, 1, "rr1_second");

    // Reject rewinds; the packet is streamed again byte-identical.
    g_acc = 0; g_rej = 1; rx_q.delete();
    load(3, 2, 8'h61);
    wait_done(3, 0, "reject");
    g_acc = 1; g_rej = 0;
    wait_done(3, 1, "restream");
    chk("restream_len", rx_q.size(), 4);
    if (rx_q.size() == 4) begin
      chk("rx_b0", rx_q[0], 8'h61);
      chk("rx_b1", rx_q[1], 8'h62);
      chk("restream_b0", rx_q[2], rx_q[0]);
      chk("restream_b1", rx_q[3], rx_q[1]);
    end

    // Stall watchdog: LIM idle cycles after a handshake, abort on the next one.
    load(2, 4, 8'h70); rx_q.delete();
    wait_rx(1);
    g_rdy = 0; ab_at = -1;
    for (int i = 1; i <= 12; i++) begin
      tick(1);
      if (g_last_ab && ab_at < 0) ab_at = i;
    end
    chk("stall_abort_cycle", ab_at, LIM + 1);
    wait_done(2, 0, "stall_rewind");
    g_rdy = 1;
    wait_done(2, 1, "stall_drain");

    // Disable after byte 1: abort next cycle, no extra pops, endpoint skipped.
    load(1, 4, 8'h80); rx_q.delete();
    wait_rx(1);
    g_en[1] = 0; ab_at = -1;
    for (int i = 1; i <= 4; i++) begin
      tick(1);
      if (g_last_ab && ab_at < 0) ab_at = i;
    end
    chk("disable_abort_cycle", ab_at, 2);
    chk("disable_no_pop", rx_q.size(), 1);
    chk("disable_rewound", ro[1], 0);
    wait_done(1, 0, "disable_done");
    load(2, 2, 8'h90);
    wait_done(2, 1, "skip_disabled");
    g_en[1] = 1;
    wait_done(1, 1, "reenable");

    // Reset during WAIT_VERDICT with accept high: no Done, rr back to 0.
    g_acc = 0; g_rej = 0; rx_q.delete();
    load(2, 2, 8'hA0);
    wait_rx(2);
    tick(1); tick(1);
    g_acc = 1;
    tick(0);
    for (int e = 0; e < N; e++) ro[e] = 0;
    load(1, 2, 8'hB0); load(3, 2, 8'hC0);
    tick(1);
    chk("reset_no_done", done_ep_q.size(), 0);
    wait_done(1, 1, "post_reset_rr0");

    // Randomized traffic with BRAM gaps, backpressure, verdicts and enable flips.
    for (int c = 0; c < 3000; c++) begin
      for (int e = 0; e < N; e++) begin
        g_gap[e] = ($urandom % 4) == 0;
        if ($urandom % 150 == 0) g_en[e] = ~g_en[e];
        if (!has[e] && ($urandom % 8 == 0)) begin
          load(e, 1 + int'($urandom % 6), 8'($urandom));
          for (int b = 0; b < plen[e]; b++) pk[e][b] = 8'($urandom);
        end
      end
      g_rdy = ($urandom % 4) != 0;
      g_acc = ($urandom % 3) == 0;
      g_rej = ($urandom % 3) == 1;
      tick(1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
